// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: op codes, FSM states,
// decode patterns and the per-operation context latched at issue.
package div_sequencer_pkg;

   // funct3[1:0] of the M-extension divide group
   typedef enum logic [1:0] {
      ALU_DIV  = 2'b00,
      ALU_DIVU = 2'b01,
      ALU_REM  = 2'b10,
      ALU_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // R-type OP, funct7=0000001; match under DIV_INST_MASK
   localparam logic [31:0] DIV_INST_MASK = 32'hFE00_707F;
   localparam logic [31:0] DIV_INST      = 32'h0200_4033;
   localparam logic [31:0] DIVU_INST     = 32'h0200_5033;
   localparam logic [31:0] REM_INST      = 32'h0200_6033;
   localparam logic [31:0] REMU_INST     = 32'h0200_7033;

   typedef struct packed {
      logic is_rem;
      logic neg_q;
      logic neg_r;
   } div_ctx_t;

   function automatic logic is_div_inst(input logic [31:0] inst);
      logic [31:0] m;
      m = inst & DIV_INST_MASK;
      return (m == DIV_INST) || (m == DIVU_INST) ||
             (m == REM_INST) || (m == REMU_INST);
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift {R,Q} left, trial-subtract D.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   r,
   input  logic [XLEN-1:0] q,
   input  logic [XLEN-1:0] d,
   output logic [XLEN:0]   r_next,
   output logic [XLEN-1:0] q_next
);

   logic [XLEN:0] r_sh;
   logic [XLEN:0] trial;
   logic          fits;

   assign r_sh  = {r[XLEN-1:0], q[XLEN-1]};
   assign trial = r_sh - {1'b0, d};
   // a bit shifted out of R means the shifted value already exceeds D
   assign fits  = r[XLEN] | ~trial[XLEN];

   assign r_next = fits ? trial : r_sh;
   assign q_next = {q[XLEN-2:0], fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: magnitude restoring divide,
// sign fix, registered result with a one-cycle done pulse.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state, state_n;
   logic [4:0]      cnt;
   logic [XLEN:0]   r_q;
   logic [XLEN-1:0] q_q, d_q;
   div_ctx_t        ctx;

   logic            accept, is_signed, a_neg, b_neg;
   logic            fast_zero, fast_ovf, fast;
   logic [XLEN-1:0] mag_a, mag_b, fast_res;
   logic [XLEN:0]   r_step;
   logic [XLEN-1:0] q_step, q_fix, r_fix, fix_res;

   assign accept    = start & ~kill & ((state == DIV_IDLE) | (state == DIV_DONE));
   assign is_signed = ~op[0];
   assign a_neg     = is_signed & opa[XLEN-1];
   assign b_neg     = is_signed & opb[XLEN-1];
   assign mag_a     = a_neg ? -opa : opa;
   assign mag_b     = b_neg ? -opb : opb;

   // divide-by-zero and signed overflow bypass the iteration entirely
   assign fast_zero = (opb == '0);
   assign fast_ovf  = is_signed & (opa == MIN_NEG) & (&opb);
   assign fast      = fast_zero | fast_ovf;
   always_comb begin
      fast_res = '0;
      if (fast_zero)  fast_res = op[1] ? opa : '1;
      else if (fast_ovf) fast_res = op[1] ? '0 : MIN_NEG;
   end

   div_step #(.XLEN(XLEN)) u_step (
      .r      (r_q),
      .q      (q_q),
      .d      (d_q),
      .r_next (r_step),
      .q_next (q_step)
   );

   assign q_fix   = ctx.neg_q ? -q_q : q_q;
   assign r_fix   = ctx.neg_r ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
   assign fix_res = ctx.is_rem ? r_fix : q_fix;

   assign busy = (state == DIV_CALC) | (state == DIV_FIX);

   always_comb begin
      state_n = state;
      case (state)
         DIV_IDLE, DIV_DONE: begin
            if (accept) state_n = fast ? DIV_DONE : DIV_CALC;
            else        state_n = DIV_IDLE;
         end
         DIV_CALC: if (cnt == 5'd0) state_n = DIV_FIX;
         DIV_FIX:  state_n = DIV_DONE;
         default:  state_n = DIV_IDLE;
      endcase
      if (kill) state_n = DIV_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= DIV_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= (state_n == DIV_DONE);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         r_q    <= '0;
         q_q    <= '0;
         d_q    <= '0;
         ctx    <= '0;
         result <= '0;
      end else begin
         if (accept) begin
            ctx.is_rem <= op[1];
            ctx.neg_q  <= a_neg ^ b_neg;
            ctx.neg_r  <= a_neg;
            cnt        <= 5'd31;
            r_q        <= '0;
            q_q        <= mag_a;
            d_q        <= mag_b;
            if (fast) result <= fast_res;
         end else if (state == DIV_CALC && !kill) begin
            r_q <= r_step;
            q_q <= q_step;
            cnt <= cnt - 5'd1;
         end
         if (state == DIV_FIX && !kill) result <= fix_res;
      end
   end

endmodule
